pool_rd_sched: RTL
==================

POOL_RD_SCHED -- requirements
Module: pool_rd_sched

Interface
REQ-001 Parameter LENPSUM, default 16, psum rows per frame and psums per row; frame = LENPSUM*LENPSUM beats.
REQ-002 Parameter PSUM_WIDTH, default 16, bits per psum.
REQ-003 Parameter BLOCK_DEPTH, default 32, psum lanes per beat.
REQ-004 Parameter POOL_KERNEL_WIDTH, default 3, kernel-size field width.
REQ-005 Parameter AW, default clog2(LENPSUM*LENPSUM), read-address width.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 cfg_pool  in  1+POOL_KERNEL_WIDTH  MSB = pool enable; low bits = kernel size.
REQ-009 start  in  1  single-cycle pulse: PE buffer holds a complete frame.
REQ-010 busy  out  1  high from accepted start until done.
REQ-011 done  out  1  single-cycle frame-complete pulse.
REQ-012 cfg_err  out  1  sticky illegal-kernel flag, cleared by next accepted start.
REQ-013 pel_en_rd  out  1  PE buffer read enable; data returns 1 cycle later.
REQ-014 pel_addr_rd  out  AW  PE buffer read address.
REQ-015 pel_dat  in  PSUM_WIDTH*BLOCK_DEPTH  PE buffer read data.
REQ-016 pool_wr_req  out  1  push beat to pooling unit.
REQ-017 pool_wr_dat  out  PSUM_WIDTH*BLOCK_DEPTH  beat data.
REQ-018 pool_wr_ready  in  1  pooling unit not full; beat transfers when req&&ready.
REQ-019 pool_ctrl  out  2  bit0 = first beat of row; bit1 = last beat of frame; valid with pool_wr_req.

Function
REQ-020 FSM states IDLE, READ, DRAIN, DONE; reset state IDLE.
REQ-021 IDLE: start accepted only in IDLE; start in any other state is ignored.
REQ-022 On accepted start, cfg_pool is latched; latched value is used for the whole frame.
REQ-023 Enable=0 at start: no reads; IDLE->DONE; done pulses next cycle; cfg_err unchanged (cleared).
REQ-024 Kernel==0 or kernel>LENPSUM at start: cfg_err=1, no reads, IDLE->DONE.
REQ-025 Otherwise IDLE->READ, address counter=0, busy=1 the cycle after start.
REQ-026 READ: pel_en_rd=1 in a cycle only if pool_wr_ready=1 and the skid register is empty; pel_addr_rd=counter; counter increments per issued read.
REQ-027 Read data is captured 1 cycle after issue into the output register if it is empty or being drained that cycle, else into the 1-entry skid register; no beat is ever dropped or duplicated.
REQ-028 pool_wr_req=1 whenever the output register is valid; pool_wr_dat/pool_ctrl are stable while req&&!ready.
REQ-029 On transfer, the skid register (if valid) moves to the output register in the same cycle.
REQ-030 pool_ctrl[0]=1 for beats with address mod LENPSUM==0; pool_ctrl[1]=1 only for address LENPSUM*LENPSUM-1.
REQ-031 Issue of address LENPSUM*LENPSUM-1: READ->DRAIN; counter does not wrap; no further reads.
REQ-032 DRAIN->DONE in the cycle the pool_ctrl[1] beat transfers.
REQ-033 DONE: done=1 for exactly one cycle, busy=0 that cycle, then IDLE; start in DONE is ignored.
REQ-034 Throughput: with pool_wr_ready held high, one beat per cycle; first pool_wr_req 2 cycles after READ entry.

Reset
REQ-035 rst_n low at any time, including mid-frame, forces IDLE and clears counter, output and skid valids, latched cfg.
REQ-036 Reset values: busy=0, done=0, cfg_err=0, pel_en_rd=0, pel_addr_rd=0, pool_wr_req=0, pool_wr_dat=0, pool_ctrl=0.
REQ-037 Reset release requires no further initialisation; first start after release behaves per REQ-021..034.

Structure
REQ-038 FSM state encoding and pool_ctrl bit positions are defined in the shared POOL package; LENPSUM, PSUM_WIDTH, BLOCK_DEPTH, POOL_KERNEL_WIDTH come from the shared global defines.
REQ-039 Skid/output register pair is one sub-module, pool_skid_buf (valid/ready in, valid/ready out, depth 2).
REQ-040 FSM, address counter, cfg latch and error check stay in pool_rd_sched.

Verification (LENPSUM=4, frame 16 beats)
REQ-041 cfg_pool={1,2}, start, ready=1 always -> addresses 0..15 one per cycle, 16 transfers with data matching addresses, ctrl[0] on beats 0,4,8,12, ctrl[1] on beat 15, done one cycle after beat 15.
REQ-042 Same frame, ready toggling 1-0 each cycle plus 5-cycle low after beat 7 -> exactly 16 in-order transfers, data stable while stalled, no read issued while skid full.
REQ-043 cfg_pool={1,0} and {1,5} -> cfg_err=1, no pel_en_rd, done pulse; following legal start clears cfg_err and completes.
REQ-044 cfg_pool={0,2} -> no reads, no pushes, done pulse, cfg_err=0.
REQ-045 start repeated at beat 6 and during DONE -> ignored; exactly one 16-beat frame and one done.
REQ-046 rst_n asserted at beat 9 -> all outputs to reset values asynchronously; subsequent start produces full fresh frame from address 0.

Source files
------------

// File: rtl/pool_rd_sched_pkg.sv
// rtl/pool_rd_sched_pkg.sv - shared POOL definitions: global defaults, FSM encoding, pool_ctrl bit map
package pool_rd_sched_pkg;

    // Global geometry defaults shared across the pooling datapath.
    localparam int DEF_LENPSUM           = 16;
    localparam int DEF_PSUM_WIDTH        = 16;
    localparam int DEF_BLOCK_DEPTH       = 32;
    localparam int DEF_POOL_KERNEL_WIDTH = 3;

    // Read-scheduler FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

    // pool_ctrl sideband layout.
    localparam int CTRL_W         = 2;
    localparam int CTRL_FIRST_BIT = 0;   // first beat of a row
    localparam int CTRL_LAST_BIT  = 1;   // last beat of the frame

endpackage

// File: rtl/pool_skid_buf.sv
// rtl/pool_skid_buf.sv - two-entry output/skid register pair between PE buffer reads and pooling unit
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid_i   beat arriving from the PE buffer this cycle
//   in_data_i    arriving beat payload
//   in_ready_o   high when the skid entry is empty (upstream may issue a read)
//   out_valid_o  output register holds a beat
//   out_data_o   output register payload, held stable while stalled
//   out_ready_i  downstream accepts the output beat this cycle
module pool_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         out_vld_q;
    logic [W-1:0] out_dat_q;
    logic         skid_vld_q;
    logic [W-1:0] skid_dat_q;
    logic         out_free;

    // Output register can take a new beat when empty or draining this cycle.
    assign out_free    = !out_vld_q || out_ready_i;
    assign in_ready_o  = !skid_vld_q;
    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                // Older skid beat goes first; a new arrival refills the skid.
                out_vld_q  <= 1'b1;
                out_dat_q  <= skid_dat_q;
                skid_vld_q <= in_valid_i;
                if (in_valid_i) begin
                    skid_dat_q <= in_data_i;
                end
            end else begin
                out_vld_q <= in_valid_i;
                if (in_valid_i) begin
                    out_dat_q <= in_data_i;
                end
            end
        end else if (in_valid_i) begin
            // Output is stalled: park the returning read data.
            skid_vld_q <= 1'b1;
            skid_dat_q <= in_data_i;
        end
    end

endmodule

// File: rtl/pool_rd_sched.sv
// rtl/pool_rd_sched.sv - reads one PE-buffer frame and streams it to the pooling unit with flow control
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg_pool       {enable, kernel size}, latched on accepted start
//   start          frame-ready pulse, honoured only in IDLE
//   busy           frame in progress (READ/DRAIN)
//   done           one-cycle frame-complete pulse
//   cfg_err        sticky illegal-kernel flag for the last accepted start
//   pel_en_rd      PE buffer read enable (data returns next cycle)
//   pel_addr_rd    PE buffer read address
//   pel_dat        PE buffer read data
//   pool_wr_req    beat valid towards the pooling unit
//   pool_wr_dat    beat data
//   pool_wr_ready  pooling unit can accept a beat
//   pool_ctrl      {last beat of frame, first beat of row}
module pool_rd_sched
    import pool_rd_sched_pkg::*;
#(
    parameter int LENPSUM           = DEF_LENPSUM,
    parameter int PSUM_WIDTH        = DEF_PSUM_WIDTH,
    parameter int BLOCK_DEPTH       = DEF_BLOCK_DEPTH,
    parameter int POOL_KERNEL_WIDTH = DEF_POOL_KERNEL_WIDTH,
    parameter int AW                = $clog2(LENPSUM * LENPSUM)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [POOL_KERNEL_WIDTH:0]        cfg_pool,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err,
    output logic                              pel_en_rd,
    output logic [AW-1:0]                     pel_addr_rd,
    input  logic [PSUM_WIDTH*BLOCK_DEPTH-1:0] pel_dat,
    output logic                              pool_wr_req,
    output logic [PSUM_WIDTH*BLOCK_DEPTH-1:0] pool_wr_dat,
    input  logic                              pool_wr_ready,
    output logic [CTRL_W-1:0]                 pool_ctrl
);

    localparam int              DW        = PSUM_WIDTH * BLOCK_DEPTH;
    localparam int              KW        = POOL_KERNEL_WIDTH;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(LENPSUM * LENPSUM - 1);

    pool_state_e          state_q;
    logic [AW-1:0]        cnt_q;
    logic [KW:0]          cfg_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_vld_q;
    logic [CTRL_W-1:0]    rd_ctrl_q;
    logic [CTRL_W-1:0]    rd_ctrl_d;

    logic                 skid_ready;
    logic                 rd_issue;
    logic                 last_xfer;
    logic [DW+CTRL_W-1:0] out_payload;

    function automatic logic kernel_bad(input logic [KW-1:0] k);
        return (k == '0) || (32'(k) > 32'(LENPSUM));
    endfunction

    // A read is only issued when the downstream is accepting and the skid has
    // room, so the returning beat always has a register to land in.
    assign rd_issue  = (state_q == ST_READ) && pool_wr_ready && skid_ready;
    assign last_xfer = pool_wr_req && pool_wr_ready && pool_ctrl[CTRL_LAST_BIT];

    assign pel_en_rd   = rd_issue;
    assign pel_addr_rd = cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    // Derived from the latched config so it stays sticky until the next start.
    assign cfg_err     = cfg_q[KW] && kernel_bad(cfg_q[KW-1:0]);

    always_comb begin
        rd_ctrl_d                 = '0;
        rd_ctrl_d[CTRL_FIRST_BIT] = (32'(cnt_q) % 32'(LENPSUM)) == 32'd0;
        rd_ctrl_d[CTRL_LAST_BIT]  = (cnt_q == LAST_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cfg_q <= cfg_pool;
                        cnt_q <= '0;
                        if (cfg_pool[KW] && !kernel_bad(cfg_pool[KW-1:0])) begin
                            state_q <= ST_READ;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue) begin
                        // Counter parks on the last address rather than wrapping.
                        if (cnt_q == LAST_ADDR) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_xfer) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sideband travels alongside the read so it lines up with returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_ctrl_q <= '0;
        end else begin
            rd_vld_q <= rd_issue;
            if (rd_issue) begin
                rd_ctrl_q <= rd_ctrl_d;
            end
        end
    end

    pool_skid_buf #(
        .W (DW + CTRL_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rd_vld_q),
        .in_data_i   ({rd_ctrl_q, pel_dat}),
        .in_ready_o  (skid_ready),
        .out_valid_o (pool_wr_req),
        .out_data_o  (out_payload),
        .out_ready_i (pool_wr_ready)
    );

    assign pool_wr_dat = out_payload[DW-1:0];
    assign pool_ctrl   = out_payload[DW +: CTRL_W];

endmodule
